// File: rtl/nbcac_pkg.sv
// Shared widths and types for the NBCAC decoder arbiter: a 26-wire codeword
// carries one 18-bit data word.
package nbcac_pkg;

  localparam int NBCAC_CW = 26;
  localparam int NBCAC_DW = 18;

  typedef logic [26:1] nbcac_code_t;
  typedef logic [17:0] nbcac_data_t;

endpackage

// File: rtl/nbcac_decoder_arbiter_if.sv
// Requester and sink handshake bundle for nbcac_decoder_arbiter.
// The master side feeds codewords and drains results; the slave is the arbiter.
interface nbcac_decoder_arbiter_if #(
  parameter int NCH = 4,
  parameter int CW  = 26,
  parameter int DW  = 18
);

  logic                     en;
  logic [NCH-1:0]           in_valid;
  logic [NCH-1:0]           in_ready;
  logic [NCH*CW-1:0]        in_code;
  logic                     out_valid;
  logic                     out_ready;
  logic [DW-1:0]            out_data;
  logic [$clog2(NCH)-1:0]   out_ch;

  modport master (
    output en, in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  en, in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/nbcac_18di_decoder_core.sv
// Combinational NBCAC decoder: the codeword is a Fibonacci-weighted numeral,
// wire d[i] carrying weight F(i+1). Sums past 18 bits wrap (invalid codes).
module nbcac_18di_decoder_core
  import nbcac_pkg::*;
(
  input  nbcac_code_t d,
  output nbcac_data_t v
);

  localparam nbcac_data_t WEIGHT [26] = '{
    18'd1,     18'd2,     18'd3,     18'd5,     18'd8,     18'd13,
    18'd21,    18'd34,    18'd55,    18'd89,    18'd144,   18'd233,
    18'd377,   18'd610,   18'd987,   18'd1597,  18'd2584,  18'd4181,
    18'd6765,  18'd10946, 18'd17711, 18'd28657, 18'd46368, 18'd75025,
    18'd121393, 18'd196418
  };

  always_comb begin
    v = '0;
    for (int i = 0; i < 26; i++) begin
      if (d[5'(i + 1)]) v = v + WEIGHT[i];
    end
  end

endmodule

// File: rtl/nbcac_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping
// at NCH. Grants are suppressed entirely when take is low.
module nbcac_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           take,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           any_gnt
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    // Explicit subtract keeps the wrap correct for non-power-of-2 NCH.
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_gnt && req[IW'(idx)]) begin
        any_gnt = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    any_gnt = any_gnt & take;
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/nbcac_decoder_arbiter.sv
// Shares one NBCAC decoder core across NCH requesters; the decoded word is
// registered with its channel tag behind a single valid/ready output.
module nbcac_decoder_arbiter
  import nbcac_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = NBCAC_CW,
  parameter int DW  = NBCAC_DW
) (
  input  logic                   clock,
  input  logic                   rst,
  nbcac_decoder_arbiter_if.slave bus
);

  localparam int IW = $clog2(NCH);

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gnt_idx_p0;
  logic [NCH-1:0] gnt_p0;
  logic           any_gnt_p0;
  logic           take_p0;
  nbcac_code_t    code_p0;
  nbcac_data_t    data_p0;

  logic           vld_p1;
  nbcac_data_t    data_p1;
  logic [IW-1:0]  ch_p1;

  // Stage p0: arbitrate, select the granted codeword, decode.
  assign take_p0 = bus.en & ~rst & (~vld_p1 | bus.out_ready);

  nbcac_rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .take    (take_p0),
    .gnt     (gnt_p0),
    .gnt_idx (gnt_idx_p0),
    .any_gnt (any_gnt_p0)
  );

  assign bus.in_ready = gnt_p0;

  always_comb begin
    code_p0 = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_p0[i]) code_p0 = code_p0 | bus.in_code[i*CW +: CW];
    end
  end

  nbcac_18di_decoder_core u_core (
    .d (code_p0),
    .v (data_p0)
  );

  // Stage p1: output register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else if (any_gnt_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      ch_p1   <= gnt_idx_p0;
      ptr     <= (gnt_idx_p0 == IW'(NCH - 1)) ? '0 : gnt_idx_p0 + 1'b1;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;

endmodule

// File: tb/tb_nbcac_decoder_arbiter.sv
// Directed and randomized checks of nbcac_decoder_arbiter against a
// cycle-level transaction model of the arbitration and Fibonacci decode rules.
module tb_nbcac_decoder_arbiter;

  localparam int NCH = 4;
  localparam int CW  = 26;
  localparam int DW  = 18;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  nbcac_decoder_arbiter_if #(.NCH(NCH), .CW(CW), .DW(DW)) bus ();

  nbcac_decoder_arbiter #(.NCH(NCH), .CW(CW), .DW(DW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  int                m_ptr;
  bit                m_vld;
  logic [DW-1:0]     m_data;
  int                m_ch;
  logic [CW-1:0]     codes [NCH];
  logic [DW-1:0]     held_data;
  logic [31:0]       held_ch;

  function automatic logic [DW-1:0] ref_decode(input logic [CW-1:0] c);
    int unsigned a = 1, b = 2, t, sum = 0;
    for (int i = 0; i < CW; i++) begin
      if (c[i]) sum += a;
      t = a + b;
      a = b;
      b = t;
    end
    return DW'(sum);
  endfunction

  function automatic int ref_grant();
    if (!(bus.en && !rst && (!m_vld || bus.out_ready))) return -1;
    for (int k = 0; k < NCH; k++) begin
      int c = (m_ptr + k) % NCH;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_codes();
    for (int i = 0; i < NCH; i++) bus.in_code[i*CW +: CW] = codes[i];
  endtask

  task automatic cycle(input string tag);
    int g;
    @(negedge clock);
    g = ref_grant();
    chk({tag, ".in_ready"}, 32'(bus.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_vld));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(m_data));
    chk({tag, ".out_ch"}, 32'(bus.out_ch), 32'(m_ch));
    @(posedge clock);
    if (rst) begin
      m_vld = 0; m_data = '0; m_ch = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_vld  = 1;
      m_data = ref_decode(codes[g]);
      m_ch   = g;
      m_ptr  = (g + 1) % NCH;
    end else if (m_vld && bus.out_ready) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic rand_codes();
    for (int i = 0; i < NCH; i++)
      codes[i] = ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom());
    apply_codes();
  endtask

  initial begin
    m_ptr = 0; m_vld = 0; m_data = '0; m_ch = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = '1;
    rand_codes();
    @(posedge clock);
    #1;

    // Reset held with every channel requesting.
    cycle("rst0");
    cycle("rst1");
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_data", 32'(bus.out_data), 32'd0);
    chk("rst.out_ch", 32'(bus.out_ch), 32'd0);
    rst = 1'b0;
    cycle("first");
    chk("first.ch", 32'(bus.out_ch), 32'd0);
    chk("first.valid", 32'(bus.out_valid), 32'd1);

    // Round robin, channel 1 always sends the all-zero codeword.
    for (int i = 0; i < 8; i++) begin
      rand_codes();
      codes[1] = '0;
      apply_codes();
      cycle("rr");
      chk("rr.ch", 32'(bus.out_ch), 32'((i + 1) % NCH));
      chk("rr.valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_ch == 2'd1) chk("rr.zero", 32'(bus.out_data), 32'd0);
    end

    // Sparse requests starting with ptr = 2.
    bus.in_valid = 4'b0010;
    rand_codes();
    cycle("sp.set");
    chk("sp.set.ch", 32'(bus.out_ch), 32'd1);
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rand_codes();
      cycle("sp");
      chk("sp.ch", 32'(bus.out_ch), (i % 2 == 0) ? 32'd3 : 32'd1);
    end
    bus.in_valid = '0;
    for (int i = 0; i < 5; i++) cycle("idle");
    chk("idle.valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = '1;
    rand_codes();
    cycle("sp.after");
    chk("sp.after.ch", 32'(bus.out_ch), 32'd2);

    // Backpressure with a word held.
    held_data = bus.out_data;
    held_ch   = 32'(bus.out_ch);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_codes();
      cycle("bp");
      chk("bp.data", 32'(bus.out_data), 32'(held_data));
      chk("bp.ch", 32'(held_ch), 32'(bus.out_ch));
      chk("bp.rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    cycle("bp.rel");
    chk("bp.rel.ch", 32'(bus.out_ch), 32'd3);
    chk("bp.rel.valid", 32'(bus.out_valid), 32'd1);

    // Enable low drains without granting.
    bus.en = 1'b0;
    cycle("en0");
    chk("en0.valid", 32'(bus.out_valid), 32'd0);
    cycle("en1");
    chk("en1.valid", 32'(bus.out_valid), 32'd0);
    bus.en = 1'b1;
    cycle("en.back");
    chk("en.back.ch", 32'(bus.out_ch), 32'd0);

    // Reset while a word is held discards it.
    bus.out_ready = 1'b0;
    cycle("mr.hold");
    rst = 1'b1;
    cycle("mr.rst");
    chk("mr.valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    cycle("mr.after");
    chk("mr.after.valid", 32'(bus.out_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = NCH'($urandom());
      bus.en        = ($urandom_range(0, 7) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 63) == 0);
      rand_codes();
      cycle("rnd");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nbcac_decoder_arbiter.md
# nbcac_decoder_arbiter

Shares one combinational `nbcac_18di_decoder_core` between NCH requester channels. Each channel offers 26-bit NBCAC codewords over a valid/ready handshake. A round-robin arbiter grants at most one channel per cycle. The 18-bit result is registered with its channel tag on a single output valid/ready port. The block sits between per-link CAC receive buffers and the downstream data sink, replacing one decoder instance per link.

## Interface
Parameters:
- `NCH`, 4: number of requester channels (2..16)
- `CW`, 26: codeword width; fixed by decoder core
- `DW`, 18: decoded data width; fixed by decoder core

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  grant enable; low blocks new grants, output still drains
- `in_valid`  in  NCH  channel i has a codeword
- `in_ready`  out  NCH  channel i codeword accepted this cycle (one-hot or zero)
- `in_code`  in  NCH*CW  channel i codeword at bits [i*CW +: CW]; bit order matches core `d[26:1]`
- `out_valid`  out  1  output register holds a decoded word
- `out_ready`  in  1  sink accepts output this cycle
- `out_data`  out  DW  decoded data
- `out_ch`  out  $clog2(NCH)  channel index of `out_data`

## Operation
- State:
  - `ptr`: round-robin pointer, $clog2(NCH) bits
  - output register: `out_valid`, `out_data`, `out_ch`
- Acceptance: `take = en & (~out_valid | out_ready)`.
- Arbitration:
  - Grant g is the first index with `in_valid` set, searching ptr, ptr+1, …, wrapping modulo NCH.
  - `in_ready[g] = take & any(in_valid)`; all other bits are 0.
- On a grant:
  - `out_data <= core(in_code[g])`, `out_ch <= g`, `out_valid <= 1`
  - `ptr <= (g+1) mod NCH`; wrap for non-power-of-2 NCH is explicit.
- No grant but `out_valid & out_ready`: `out_valid <= 0`; data and channel registers hold their values.
- No grant or no valid input: `ptr` is unchanged.
- Stall (`out_valid & ~out_ready`):
  - all `in_ready` are 0;
  - output register is held stable;
  - `ptr` holds.
- `en` low:
  - no grants and `ptr` holds;
  - a pending output still drains on `out_ready`.
- `in_ready` depends combinationally on `in_valid`, `en` and `out_ready`. Sources must not make `in_valid` depend on `in_ready`.
- Decoder core is purely combinational. Invalid (non-NBCAC) codewords pass through with whatever value the core produces; no error flag.

## Timing
- Reset (`rst` high at a clock edge):
  - `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`
  - `in_ready=0` while `rst` is asserted
- Reset mid-operation discards any held output word, with no handshake.
- Latency: codeword accepted at edge N appears on `out_data` after edge N, i.e. valid in cycle N+1.
- Throughput: one word per cycle while `out_ready=1`. Simultaneous drain and accept in the same cycle gives no bubble.
- Fairness: a continuously valid channel waits at most NCH-1 grants.
- Critical path: arbiter → NCH:1 codeword mux → decoder core → output register. No pipelining inside the block.

## Structure
- Package `nbcac_pkg`:
  - `NBCAC_CW=26`, `NBCAC_DW=18`
  - typedefs `nbcac_code_t` (logic [26:1]) and `nbcac_data_t` (logic [17:0])
- Sub-module `nbcac_rr_arbiter`:
  - inputs: `req[NCH]`, `ptr`, `take`
  - outputs: one-hot `gnt`, encoded `gnt_idx`, `any_gnt`
  - combinational only; `ptr` lives in the top block
- Top block contains:
  - one `nbcac_18di_decoder_core` instance (port names `v`, `d`)
  - the codeword mux
  - the output register and `ptr` logic
- Expected size ≈150–250 lines.

## Test plan
- Reset:
  - hold `rst` 2 cycles with all `in_valid=1`;
  - require `out_valid=0`, `out_data=0`, `out_ch=0`, `in_ready=0`;
  - first grant after release goes to channel 0.
- Round-robin:
  - NCH=4, all channels valid, `out_ready=1`;
  - require `out_ch` sequence 0,1,2,3,0,… with one word per cycle;
  - `out_data` matches the reference model for each codeword; `in_code=0` gives `out_data=18'h0`.
- Sparse requests:
  - only channels 1 and 3 valid, `ptr=2` → grant 3, then 1, then 3;
  - with no valid input for 5 cycles, `ptr` is unchanged.
- Backpressure:
  - `out_ready=0` for 4 cycles with a word held;
  - require `out_data`/`out_ch` stable and `in_ready=0`;
  - on release, the drain and the next grant happen in the same cycle.
- Enable and mid-operation reset:
  - `en=0` with `out_valid=1`, `out_ready=1` → word drains, no new grant;
  - `rst` pulsed while `out_valid=1` → `out_valid=0` next cycle and the word is never delivered.
